// File: rtl/uart_receiver_if.sv
// Receiver-side bundle: oversample tick and serial line in, received word and status pulses out.
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic                 enable;
  logic                 rxDataIn;
  logic [DATA_BITS-1:0] rxDataOut;
  logic                 rxValid;
  logic                 rxBusy;
  logic                 framingError;

  modport master (
    output enable,
    output rxDataIn,
    input  rxDataOut,
    input  rxValid,
    input  rxBusy,
    input  framingError
  );

  modport slave (
    input  enable,
    input  rxDataIn,
    output rxDataOut,
    output rxValid,
    output rxBusy,
    output framingError
  );
endinterface

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: 2-flop line sync, mid-bit sampling, LSB-first word assembly,
// one-cycle valid / framing-error pulses, and a break state that waits for the line to recover.
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_receiver_if.slave rx
);
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS) + 1;
  localparam logic [CNT_W-1:0] MID_START = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t               state_q;
  logic                 sync1_q;
  logic                 rxs_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [DATA_BITS-1:0] bit_mask_s;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 ferr_q;

  // Overwrite only the bit selected by the current index with the synchronized line value.
  always_comb begin
    bit_mask_s = DATA_BITS'(1'b1) << bit_idx_q;
    if (rxs_q) begin
      shift_d = shift_q | bit_mask_s;
    end else begin
      shift_d = shift_q & ~bit_mask_s;
    end
  end

  // Line synchronizer, frame FSM and registered outputs; pulses self-clear every clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      rxs_q     <= 1'b1;
      cnt_q     <= {CNT_W{1'b0}};
      bit_idx_q <= {IDX_W{1'b0}};
      shift_q   <= {DATA_BITS{1'b0}};
      data_q    <= {DATA_BITS{1'b0}};
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync1_q <= rx.rxDataIn;
      rxs_q   <= sync1_q;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (rx.enable) begin
        case (state_q)
          IDLE: begin
            if (!rxs_q) begin
              state_q <= START;
              cnt_q   <= {CNT_W{1'b0}};
              busy_q  <= 1'b1;
            end
          end
          START: begin
            if (cnt_q == MID_START) begin
              if (rxs_q) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q   <= DATA;
                cnt_q     <= {CNT_W{1'b0}};
                bit_idx_q <= {IDX_W{1'b0}};
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          DATA: begin
            if (cnt_q == FULL_BIT) begin
              shift_q <= shift_d;
              cnt_q   <= {CNT_W{1'b0}};
              if (bit_idx_q == LAST_IDX) begin
                state_q <= STOP;
              end else begin
                bit_idx_q <= bit_idx_q + IDX_W'(1);
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          STOP: begin
            if (cnt_q == FULL_BIT) begin
              cnt_q <= {CNT_W{1'b0}};
              if (rxs_q) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                ferr_q  <= 1'b1;
                state_q <= BRK;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          // A held-low line must go high before a new start can be recognised.
          BRK: begin
            if (rxs_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx.rxDataOut    = data_q;
  assign rx.rxValid      = valid_q;
  assign rx.rxBusy       = busy_q;
  assign rx.framingError = ferr_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: an 8N1/x16 instance and a 7N1/x8 instance on a shared tick.
module tb_uart_receiver;
  localparam int EN_DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  uart_receiver_if #(.DATA_BITS(8)) ifa ();
  uart_receiver_if #(.DATA_BITS(7)) ifb ();

  uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .rx    (ifa.slave)
  );

  uart_receiver #(.DATA_BITS(7), .OVERSAMPLE(8)) dut_b (
    .clk   (clk),
    .reset (reset),
    .rx    (ifb.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  int          va_cnt = 0;
  int          fa_cnt = 0;
  int          vb_cnt = 0;
  int          fb_cnt = 0;
  logic [7:0]  va_last = 8'h00;
  logic [7:0]  va_prev = 8'h00;
  logic [6:0]  vb_last = 7'h00;
  int unsigned vb_cyc = 0;

  always @(negedge clk) begin
    if (ifa.rxValid) begin
      va_cnt  <= va_cnt + 1;
      va_prev <= va_last;
      va_last <= ifa.rxDataOut;
    end
    if (ifa.framingError) fa_cnt <= fa_cnt + 1;
    if (ifb.rxValid) begin
      vb_cnt  <= vb_cnt + 1;
      vb_last <= ifb.rxDataOut;
      vb_cyc  <= cyc;
    end
    if (ifb.framingError) fb_cnt <= fb_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One oversample tick: EN_DIV clks, enable high during the last one.
  task automatic tick();
    repeat (EN_DIV - 1) begin
      @(posedge clk);
      #1;
    end
    ifa.enable = 1'b1;
    ifb.enable = 1'b1;
    @(posedge clk);
    #1;
    ifa.enable = 1'b0;
    ifb.enable = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_line(input bit sel, input logic b);
    if (sel) ifb.rxDataIn = b;
    else     ifa.rxDataIn = b;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] data, input int nbits,
                            input int os, input logic stop_bit, input bit chk_busy);
    set_line(sel, 1'b0);
    ticks(os);
    if (chk_busy) check_eq("busy_in_frame", 32'(sel ? ifb.rxBusy : ifa.rxBusy), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      set_line(sel, data[i]);
      ticks(os);
    end
    set_line(sel, stop_bit);
    ticks(os);
  endtask

  int unsigned b_start;
  logic [7:0]  frame_5a;

  initial begin
    reset         = 1'b0;
    ifa.enable    = 1'b0;
    ifb.enable    = 1'b0;
    ifa.rxDataIn  = 1'b1;
    ifb.rxDataIn  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data",  32'(ifa.rxDataOut),    32'h0);
    check_eq("rst_valid", 32'(ifa.rxValid),      32'd0);
    check_eq("rst_busy",  32'(ifa.rxBusy),       32'd0);
    check_eq("rst_ferr",  32'(ifa.framingError), 32'd0);
    reset = 1'b1;
    ticks(20);

    // Single good frame 0xA5.
    send_frame(1'b0, 8'hA5, 8, 16, 1'b1, 1'b1);
    ticks(4);
    check_eq("a5_count", 32'(va_cnt),        32'd1);
    check_eq("a5_data",  32'(va_last),       32'hA5);
    check_eq("a5_out",   32'(ifa.rxDataOut), 32'hA5);
    check_eq("a5_ferr",  32'(fa_cnt),        32'd0);
    check_eq("a5_idle",  32'(ifa.rxBusy),    32'd0);

    // Back-to-back frames with no idle time between them.
    send_frame(1'b0, 8'h00, 8, 16, 1'b1, 1'b0);
    send_frame(1'b0, 8'hFF, 8, 16, 1'b1, 1'b0);
    ticks(4);
    check_eq("b2b_count", 32'(va_cnt),  32'd3);
    check_eq("b2b_first", 32'(va_prev), 32'h00);
    check_eq("b2b_second",32'(va_last), 32'hFF);

    // Short low glitch aborts in START.
    set_line(1'b0, 1'b0);
    ticks(3);
    check_eq("glitch_busy", 32'(ifa.rxBusy), 32'd1);
    set_line(1'b0, 1'b1);
    ticks(20);
    check_eq("glitch_idle",  32'(ifa.rxBusy), 32'd0);
    check_eq("glitch_valid", 32'(va_cnt),     32'd3);
    check_eq("glitch_ferr",  32'(fa_cnt),     32'd0);

    // Stop bit low, line held low 40 ticks in total, then recovery.
    send_frame(1'b0, 8'h3C, 8, 16, 1'b0, 1'b0);
    ticks(24);
    check_eq("fe_count", 32'(fa_cnt),        32'd1);
    check_eq("fe_valid", 32'(va_cnt),        32'd3);
    check_eq("fe_hold",  32'(ifa.rxDataOut), 32'hFF);
    check_eq("fe_break", 32'(ifa.rxBusy),    32'd1);
    set_line(1'b0, 1'b1);
    ticks(20);
    check_eq("fe_recover", 32'(ifa.rxBusy), 32'd0);
    send_frame(1'b0, 8'h81, 8, 16, 1'b1, 1'b0);
    ticks(4);
    check_eq("after_fe_count", 32'(va_cnt),  32'd4);
    check_eq("after_fe_data",  32'(va_last), 32'h81);
    check_eq("after_fe_ferr",  32'(fa_cnt),  32'd1);

    // Reset pulse in the middle of data bit 4 of 0x5A; the rest of the frame is dropped.
    frame_5a = 8'h5A;
    set_line(1'b0, 1'b0);
    ticks(16);
    for (int i = 0; i < 4; i++) begin
      set_line(1'b0, frame_5a[i]);
      ticks(16);
    end
    set_line(1'b0, frame_5a[4]);
    ticks(8);
    check_eq("mid_busy", 32'(ifa.rxBusy), 32'd1);
    reset = 1'b0;
    #2;
    check_eq("arst_data",  32'(ifa.rxDataOut),    32'h0);
    check_eq("arst_busy",  32'(ifa.rxBusy),       32'd0);
    check_eq("arst_valid", 32'(ifa.rxValid),      32'd0);
    check_eq("arst_ferr",  32'(ifa.framingError), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    set_line(1'b0, 1'b1);
    ticks(200);
    check_eq("partial_valid", 32'(va_cnt), 32'd4);
    check_eq("partial_ferr",  32'(fa_cnt), 32'd1);
    send_frame(1'b0, 8'hC3, 8, 16, 1'b1, 1'b0);
    ticks(4);
    check_eq("c3_count", 32'(va_cnt),  32'd5);
    check_eq("c3_data",  32'(va_last), 32'hC3);

    // 7-bit, x8 instance: 68-tick latency from the detecting tick, which lands EN_DIV clks after
    // the line edge, so rxValid rises EN_DIV*(68+1) = 276 clks after the line is driven low.
    b_start = cyc;
    send_frame(1'b1, 8'h55, 7, 8, 1'b1, 1'b0);
    ticks(4);
    check_eq("b_count",   32'(vb_cnt),            32'd1);
    check_eq("b_data",    32'(vb_last),           32'h55);
    check_eq("b_latency", 32'(vb_cyc - b_start),  32'd276);
    check_eq("b_ferr",    32'(fb_cnt),            32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
